// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data-memory responder.
// Used by dmem_responder and its storage array.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam int unsigned WORD_BYTES = 4;

    // Misaligned or beyond the last word; the full upper address is compared, so nothing aliases.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return ((addr % WORD_BYTES) != 0) || ((addr / WORD_BYTES) >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read.
module dmem_array #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; contents survive reset and clearing them would cost a write port per word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data memory with programmable wait states.
// Optional access counters are enabled by defining DMEM_ACCESS_COUNT_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    dmem_state_t       state, state_next;
    logic              we_q, err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept, enter_resp, mem_we;
    logic              acc_we, acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata, mem_rdata;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt_q == CNT_W'(1)) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    assign accept     = req_valid & req_ready;
    assign enter_resp = (state != RESP) && (state_next == RESP);

    // With zero wait states the access happens on the acceptance edge, so it must see the live request.
    // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
    always_comb begin
        acc_we    = we_q;
        acc_err   = err_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_err   = addr_err(req_addr, DEPTH);
            acc_idx   = req_addr[IDX_W+1:2];
            acc_wdata = req_wdata;
        end
    end

    assign mem_we = enter_resp & acc_we & ~acc_err;

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                err_q   <= addr_err(req_addr, DEPTH);
                idx_q   <= req_addr[IDX_W+1:2];
                wdata_q <= req_wdata;
                if (WAIT_CYCLES != 0) begin
                    cnt_q <= CNT_W'(WAIT_CYCLES);
                end
            end else if (state == WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (enter_resp) begin
                rsp_rdata <= (!acc_we && !acc_err) ? mem_rdata : '0;
                rsp_err   <= acc_err;
            end
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (enter_resp && !acc_err) begin
            if (acc_we) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; counter checks are built when DMEM_ACCESS_COUNT_EN is defined.
module tb_dmem_responder;

    localparam int unsigned DEPTH       = 64;
    localparam int unsigned WAIT_CYCLES = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] rd_count, wr_count;
`endif

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [31:0] mem_model [DEPTH];
    time         last_acc;

    dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES),
        .DATA_W      (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef DMEM_ACCESS_COUNT_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // One complete transaction, entered and left at a falling edge.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input bit poke, input string name);
        exp_t        e;
        int          lat;
        int          idx;
        logic        aerr;
        logic [31:0] r0;
        logic        e0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b0;
        lat = 0;
        while (req_ready !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: req_ready=%b expected 1", name, req_ready);
        end
        @(posedge clk);
        last_acc = $time;
        aerr = (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH);
        idx  = int'(addr[31:2]);
        e.err   = aerr;
        e.rdata = (we || aerr) ? 32'h0 : mem_model[idx];
        if (we && !aerr) mem_model[idx] = wdata;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: req_ready=%b expected 0", name, req_ready);
        end
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != WAIT_CYCLES + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, WAIT_CYCLES + 1);
        end
        r0 = rsp_rdata;
        e0 = rsp_err;
        if (poke) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h20;
            req_wdata = 32'hBAD0_BAD0;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b expected 1 %h %b 0",
                         name, i, rsp_valid, rsp_rdata, rsp_err, req_ready, r0, e0);
            end
        end
        rsp_ready = 1'b1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: response with no expected entry", name);
        end else begin
            e = sb.pop_front();
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                errors++;
                $display("FAIL %s data: rdata=%h err=%b expected %h %b", name, rsp_rdata, rsp_err, e.rdata, e.err);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: rsp_valid=%b req_ready=%b expected 0 1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_store_load();
        send(1'b1, 32'h00, 32'h0000_0A00, 0, 1'b0, "fill00");
        send(1'b1, 32'h04, 32'h1111_2222, 0, 1'b0, "fill04");
        send(1'b1, 32'h10, 32'hA5A5_0010, 0, 1'b0, "fill10");
        send(1'b1, 32'h20, 32'h2020_2020, 0, 1'b0, "fill20");
        send(1'b1, 32'hFC, 32'hFCFC_FCFC, 0, 1'b0, "fillFC");
        send(1'b1, 32'h08, 32'hDEAD_BEEF, 0, 1'b0, "store08");
        send(1'b0, 32'h08, 32'h0,         0, 1'b0, "load08");
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0BAD_F00D;
        @(posedge clk);
        if (WAIT_CYCLES == 0) mem_model[4] = 32'h0BAD_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: valid=%b ready=%b rdata=%h err=%b expected 0 1 0 0",
                     rsp_valid, req_ready, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        reset = 1'b1;
        send(1'b0, 32'h10, 32'h0, 0, 1'b0, "load10_after_reset");
    endtask

    task automatic test_misaligned();
        send(1'b1, 32'h06, 32'h6666_6666, 0, 1'b0, "store06_misaligned");
        send(1'b0, 32'h04, 32'h0,         0, 1'b0, "load04_unchanged");
        send(1'b0, 32'h03, 32'h0,         0, 1'b0, "load03_misaligned");
    endtask

    task automatic test_out_of_range();
        send(1'b0, 32'h100,       32'h0,         0, 1'b0, "load100_oor");
        send(1'b0, 32'hFC,        32'h0,         0, 1'b0, "loadFC_last");
        send(1'b1, 32'h100,       32'h5555_5555, 0, 1'b0, "store100_oor");
        send(1'b0, 32'h00,        32'h0,         0, 1'b0, "load00_no_alias");
        send(1'b0, 32'hFFFF_FFFC, 32'h0,         0, 1'b0, "loadTop_oor");
    endtask

    task automatic test_backpressure();
        send(1'b0, 32'h08, 32'h0, 5, 1'b1, "bp_load08");
        send(1'b0, 32'h20, 32'h0, 0, 1'b0, "bp_ignored_store");
        send(1'b1, 32'h0C, 32'hC0C0_C0C0, 3, 1'b0, "bp_store0C");
    endtask

    task automatic test_back_to_back();
        time t0;
        send(1'b1, 32'h18, 32'h1818_1818, 0, 1'b0, "b2b_store18");
        t0 = last_acc;
        send(1'b0, 32'h18, 32'h0, 0, 1'b0, "b2b_load18");
        checks++;
        if ((last_acc - t0) / 10 != WAIT_CYCLES + 2) begin
            errors++;
            $display("FAIL b2b_throughput: got %0d cycles expected %0d", (last_acc - t0) / 10, WAIT_CYCLES + 2);
        end
        t0 = last_acc;
        send(1'b0, 32'h0C, 32'h0, 0, 1'b0, "b2b_load0C");
        checks++;
        if ((last_acc - t0) / 10 != WAIT_CYCLES + 2) begin
            errors++;
            $display("FAIL b2b_throughput2: got %0d cycles expected %0d", (last_acc - t0) / 10, WAIT_CYCLES + 2);
        end
    endtask

`ifdef DMEM_ACCESS_COUNT_EN
    task automatic test_counts();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
            errors++;
            $display("FAIL count_reset: rd=%0d wr=%0d expected 0 0", rd_count, wr_count);
        end
        send(1'b0, 32'h08,  32'h0,         0, 1'b0, "cnt_load1");
        send(1'b1, 32'h14,  32'h1414_1414, 0, 1'b0, "cnt_store1");
        send(1'b0, 32'h14,  32'h0,         0, 1'b0, "cnt_load2");
        send(1'b1, 32'h1C,  32'h1C1C_1C1C, 0, 1'b0, "cnt_store2");
        send(1'b0, 32'h101, 32'h0,         0, 1'b0, "cnt_error");
        send(1'b0, 32'h1C,  32'h0,         0, 1'b0, "cnt_load3");
        checks++;
        if (rd_count !== 16'd3 || wr_count !== 16'd2) begin
            errors++;
            $display("FAIL counts: rd=%0d wr=%0d expected 3 2", rd_count, wr_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_reset_mid_wait();
        test_misaligned();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
`ifdef DMEM_ACCESS_COUNT_EN
        test_counts();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed data-memory responder: the target end of the datapath's load/store interface, replacing the zero-latency data memory with a handshaked, multi-cycle one.
- Accepts one request at a time over a valid/ready channel, waits a programmable number of cycles, then performs the access and returns read data or an error on a valid/ready response channel.
- Sits between the datapath's memory port (ALU result as address, RD2 as write data) and the storage array.

Parameters:
- DEPTH, 64, number of 32-bit words stored.
- WAIT_CYCLES, 2, wait states between acceptance and response (0 allowed).
- DATA_W, 32, data width; fixed at 32 for this design.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or out-of-range access.

Behaviour:
- FSM states are IDLE, WAIT and RESP. Reset forces IDLE and the following outputs:
  - req_ready=1
  - rsp_valid=0
  - rsp_rdata=0
  - rsp_err=0
  - wait counter=0
- Storage contents are not reset.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we, addr and wdata.
  - Set err_q = (addr[1:0]!=0) | (addr[31:2] >= DEPTH).
  - If WAIT_CYCLES==0, go to RESP; otherwise load the counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - req_ready=0; the counter decrements every cycle.
  - When the counter reaches 1, go to RESP on the next edge.
- Transition into RESP, on the same edge:
  - If we & !err_q, write wdata to mem[addr[31:2]].
  - If !we & !err_q, rsp_rdata <= mem[addr[31:2]]; otherwise rsp_rdata <= 0.
  - rsp_err <= err_q.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE with rsp_valid=0.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the acceptance edge.
- Only one request is outstanding at a time. A new request can be accepted no earlier than the cycle after the response handshake, so back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Read-after-write: a store is committed before its response, so a following load returns the new data.
- Errored stores leave memory unchanged.
- Address bits above the index are compared in full; there is no aliasing or wrap-around.
- Reset mid-operation: returns to IDLE immediately and discards any pending store. A store already committed stays committed.
- req_valid asserted in WAIT or RESP is ignored; the requester must hold it until req_ready.

Optional Feature:
- Macro: DMEM_ACCESS_COUNT_EN.
- When defined, add outputs rd_count[15:0] and wr_count[15:0].
  - Each increments on the RESP transition for successful loads or stores respectively.
  - Each saturates at 16'hFFFF and is cleared by reset.
  - Errored accesses are not counted.
- When undefined, the ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  - localparam WORD_BYTES = 4;
  - function addr_err(addr, depth).
- One natural sub-module: dmem_array, a synchronous-write, combinational-read storage array (DEPTH x 32, one port), instantiated by dmem_responder.

Test Plan:
- Reset: drive reset=0 mid-WAIT of a store to 0x10 -> rsp_valid=0 and req_ready=1 immediately; a later load of 0x10 returns the old value.
- Store then load, WAIT_CYCLES=2: store 0xDEADBEEF to 0x08 -> rsp_valid exactly 3 cycles after acceptance with rsp_err=0; load 0x08 -> rsp_rdata=0xDEADBEEF.
- Misaligned: store to 0x06 -> rsp_err=1, rsp_rdata=0; load 0x04 -> unchanged prior contents.
- Out-of-range: load address 0x100 with DEPTH=64 -> rsp_err=1, rsp_rdata=0; 0xFC -> rsp_err=0.
- Response backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0, a concurrent req_valid is ignored; assert rsp_ready -> IDLE next cycle.
- WAIT_CYCLES=0 build: load -> rsp_valid 1 cycle after acceptance. With DMEM_ACCESS_COUNT_EN: 3 loads, 2 stores and 1 error -> rd_count=3, wr_count=2.
